bram_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for one single-port block RAM with read-first behaviour and one-cycle registered read latency (image frame buffer).
- Port 0 is the pixel-processing read path; port 1 is the loader/writeback path.
- The block grants one access per cycle, drives the RAM enable, write-enable, address and data lines, and routes the returned read data back to the requester that issued the read.
- It supports a bounded burst lock so one requester can stream a row of pixels without the other port starving it or being starved.

---
 rtl/bram_arb_pkg.sv | 22 ++
 rtl/bram_rr_grant.sv | 27 ++
 rtl/bram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_bram_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-port block RAM arbiter.
package bram_arb_pkg;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int unsigned LOCK_MAX_DEF = 16;

    // Counter must be able to hold the value LOCK_MAX itself.
    function automatic int unsigned lock_cnt_width(input int unsigned lock_max);
        return $clog2(lock_max + 1);
    endfunction

    localparam int unsigned LOCK_CNT_W = lock_cnt_width(LOCK_MAX_DEF);

endpackage

// File: rtl/bram_rr_grant.sv
// Two-way round-robin pick: on a tie the port that did not win last time is chosen.
module bram_rr_grant
    import bram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt0,
    output logic gnt1
);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            if (last_grant == PORT0) begin
                gnt1 = 1'b1;
            end else begin
                gnt0 = 1'b1;
            end
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Arbitrates two requesters onto one single-port block RAM with bounded burst
// locking, and steers the one-cycle-late read data back to the issuing port.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned RAM_WIDTH     = 16,
    parameter int unsigned RAM_ADDR_BITS = 17,
    parameter int unsigned LOCK_MAX      = LOCK_MAX_DEF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [RAM_ADDR_BITS-1:0] addr0,
    input  logic [RAM_ADDR_BITS-1:0] addr1,
    input  logic [RAM_WIDTH-1:0]     wdata0,
    input  logic [RAM_WIDTH-1:0]     wdata1,
    input  logic                     lock0,
    input  logic                     lock1,
    output logic                     ack0,
    output logic                     ack1,
    output logic                     rvalid0,
    output logic                     rvalid1,
    output logic [RAM_WIDTH-1:0]     rdata0,
    output logic [RAM_WIDTH-1:0]     rdata1,
    output logic                     ram_enable,
    output logic                     ram_we,
    output logic [RAM_ADDR_BITS-1:0] ram_addr,
    output logic [RAM_WIDTH-1:0]     ram_wdata,
    input  logic [RAM_WIDTH-1:0]     ram_rdata
);

    localparam int unsigned CNT_W = lock_cnt_width(LOCK_MAX);

    arb_state_e       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             rvalid0_q, rvalid0_d;
    logic             rvalid1_q, rvalid1_d;

    logic rr_gnt0, rr_gnt1;
    logic gnt0, gnt1;
    logic cnt_full;

    bram_rr_grant u_rr (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_q),
        .gnt0       (rr_gnt0),
        .gnt1       (rr_gnt1)
    );

    assign cnt_full = (lock_cnt_q == CNT_W'(LOCK_MAX));

    // Grant selection and state/counter update.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lock_cnt_d   = lock_cnt_q;
        gnt0         = 1'b0;
        gnt1         = 1'b0;

        case (state_q)
            FREE: begin
                gnt0 = rr_gnt0;
                gnt1 = rr_gnt1;
                if (rr_gnt0 && lock0) begin
                    state_d    = LOCK0;
                    lock_cnt_d = '0;
                end else if (rr_gnt1 && lock1) begin
                    state_d    = LOCK1;
                    lock_cnt_d = '0;
                end
            end
            LOCK0: begin
                if (req0 && lock0) begin
                    if (req1 && cnt_full) begin
                        gnt1       = 1'b1;
                        state_d    = FREE;
                        lock_cnt_d = '0;
                    end else begin
                        gnt0 = 1'b1;
                        if (req1) lock_cnt_d = lock_cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Owner let go: a waiting port takes this very cycle.
                    gnt1       = req1;
                    gnt0       = req0 & ~req1;
                    state_d    = FREE;
                    lock_cnt_d = '0;
                end
            end
            LOCK1: begin
                if (req1 && lock1) begin
                    if (req0 && cnt_full) begin
                        gnt0       = 1'b1;
                        state_d    = FREE;
                        lock_cnt_d = '0;
                    end else begin
                        gnt1 = 1'b1;
                        if (req0) lock_cnt_d = lock_cnt_q + CNT_W'(1);
                    end
                end else begin
                    gnt0       = req0;
                    gnt1       = req1 & ~req0;
                    state_d    = FREE;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = FREE;
                lock_cnt_d = '0;
            end
        endcase

        if (!reset_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end

        if (gnt0) begin
            last_grant_d = PORT0;
        end else if (gnt1) begin
            last_grant_d = PORT1;
        end

        rvalid0_d = gnt0 & ~we0;
        rvalid1_d = gnt1 & ~we1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= FREE;
            last_grant_q <= PORT1;
            lock_cnt_q   <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_cnt_q   <= lock_cnt_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
        end
    end

    assign ack0       = gnt0;
    assign ack1       = gnt1;
    assign ram_enable = gnt0 | gnt1;
    assign ram_we     = (gnt0 & we0) | (gnt1 & we1);
    assign ram_addr   = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
    assign ram_wdata  = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rvalid0_q ? ram_rdata : '0;
    assign rdata1  = rvalid1_q ? ram_rdata : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed-vector scoreboard bench for bram_arbiter with a read-first block RAM behind it.
module tb_bram_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 17;

    // Per-port stimulus code: {req, we, lock}
    localparam logic [2:0] IDL = 3'b000;
    localparam logic [2:0] RD  = 3'b100;
    localparam logic [2:0] WR  = 3'b110;
    localparam logic [2:0] RDL = 3'b101;
    localparam logic [2:0] WRL = 3'b111;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic          lock0 = 1'b0, lock1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          ram_enable, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    typedef struct {
        int          cyc;
        logic [DW-1:0] data;
    } exp_t;

    exp_t ack_q[$];
    exp_t rd0_q[$];
    exp_t rd1_q[$];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    bram_arbiter #(
        .RAM_WIDTH     (DW),
        .RAM_ADDR_BITS (AW),
        .LOCK_MAX      (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0       (req0),
        .req1       (req1),
        .we0        (we0),
        .we1        (we1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .lock0      (lock0),
        .lock1      (lock1),
        .ack0       (ack0),
        .ack1       (ack1),
        .rvalid0    (rvalid0),
        .rvalid1    (rvalid1),
        .rdata0     (rdata0),
        .rdata1     (rdata1),
        .ram_enable (ram_enable),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // Read-first single-port RAM with registered output.
    always @(posedge clock) begin
        if (ram_enable) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    initial begin
        mem[5]   <= 16'hA5A5;
        mem[10]  <= 16'h1111;
        mem[11]  <= 16'h2222;
        mem[12]  <= 16'h3333;
        mem[13]  <= 16'h4444;
        mem[200] <= 16'hBEEF;
    end

    // One cycle of stimulus; eack = {ack1, ack0} expected, edata = data the acked read returns.
    task automatic step(input logic rst, input logic [2:0] p0, input logic [AW-1:0] a0,
                        input logic [DW-1:0] d0, input logic [2:0] p1, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d1, input logic [1:0] eack, input logic [DW-1:0] edata,
                        input logic mid_rst);
        exp_t e;
        @(posedge clock);
        #1;
        cyc     = cyc + 1;
        reset_n = rst;
        {req0, we0, lock0} = p0;
        {req1, we1, lock1} = p1;
        addr0  = a0;
        wdata0 = d0;
        addr1  = a1;
        wdata1 = d1;
        e.cyc  = cyc;
        e.data = DW'(eack);
        ack_q.push_back(e);
        e.cyc  = cyc + 1;
        e.data = edata;
        if (eack == 2'b01 && !p0[1] && !mid_rst) rd0_q.push_back(e);
        if (eack == 2'b10 && !p1[1] && !mid_rst) rd1_q.push_back(e);
        if (mid_rst) begin
            @(negedge clock);
            #1;
            reset_n = 1'b0;
        end
    endtask

    // Monitor: compare grants every cycle, pop read data whenever an rvalid shows up.
    always @(negedge clock) begin
        exp_t e;
        if (ack_q.size() > 0) begin
            e = ack_q.pop_front();
            n_tests = n_tests + 1;
            if ({ack1, ack0, ram_enable} !== {e.data[1:0], |e.data[1:0]} ||
                (!rvalid0 && rdata0 !== '0) || (!rvalid1 && rdata1 !== '0)) begin
                n_fail = n_fail + 1;
                $display("FAIL grant cyc=%0d: ack1/ack0/en=%b%b%b rd0=%h rd1=%h, required ack=%b idle rdata 0",
                         e.cyc, ack1, ack0, ram_enable, rdata0, rdata1, e.data[1:0]);
            end
        end
        if (rvalid0) begin
            n_tests = n_tests + 1;
            if (rd0_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL rvalid0 cyc=%0d: unexpected rvalid0 data=%h, required none", cyc, rdata0);
            end else begin
                e = rd0_q.pop_front();
                if (rdata0 !== e.data || e.cyc != cyc) begin
                    n_fail = n_fail + 1;
                    $display("FAIL rdata0: got %h at cyc %0d, required %h at cyc %0d", rdata0, cyc, e.data, e.cyc);
                end
            end
        end
        if (rvalid1) begin
            n_tests = n_tests + 1;
            if (rd1_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL rvalid1 cyc=%0d: unexpected rvalid1 data=%h, required none", cyc, rdata1);
            end else begin
                e = rd1_q.pop_front();
                if (rdata1 !== e.data || e.cyc != cyc) begin
                    n_fail = n_fail + 1;
                    $display("FAIL rdata1: got %h at cyc %0d, required %h at cyc %0d", rdata1, cyc, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset, then single read
        step(0, IDL, 0,   0,        IDL, 0,   0,        2'b00, 0,        0);
        step(0, IDL, 0,   0,        IDL, 0,   0,        2'b00, 0,        0);
        step(1, RD,  5,   0,        IDL, 0,   0,        2'b01, 16'hA5A5, 0);
        step(1, IDL, 0,   0,        IDL, 0,   0,        2'b00, 0,        0);
        // requests held during reset are not acked
        step(0, RD,  10,  0,        RD,  11,  0,        2'b00, 0,        0);
        // round robin, back-to-back reads
        step(1, RD,  10,  0,        RD,  11,  0,        2'b01, 16'h1111, 0);
        step(1, RD,  10,  0,        RD,  11,  0,        2'b10, 16'h2222, 0);
        step(1, RD,  12,  0,        RD,  13,  0,        2'b01, 16'h3333, 0);
        step(1, RD,  12,  0,        RD,  13,  0,        2'b10, 16'h4444, 0);
        // write then read same address
        step(1, IDL, 0,   0,        WR,  100, 16'h1234, 2'b10, 0,        0);
        step(1, RD,  100, 0,        IDL, 0,   0,        2'b01, 16'h1234, 0);
        step(0, IDL, 0,   0,        IDL, 0,   0,        2'b00, 0,        0);
        // lock0 with LOCK_MAX=4: 1 + 4 grants, one grant to port 1, relock
        step(1, RDL, 5,   0,        RD,  200, 0,        2'b01, 16'hA5A5, 0);
        step(1, RDL, 5,   0,        RD,  200, 0,        2'b01, 16'hA5A5, 0);
        step(1, RDL, 5,   0,        RD,  200, 0,        2'b01, 16'hA5A5, 0);
        step(1, RDL, 5,   0,        RD,  200, 0,        2'b01, 16'hA5A5, 0);
        step(1, RDL, 5,   0,        RD,  200, 0,        2'b01, 16'hA5A5, 0);
        step(1, RDL, 5,   0,        RD,  200, 0,        2'b10, 16'hBEEF, 0);
        step(1, RDL, 5,   0,        RD,  200, 0,        2'b01, 16'hA5A5, 0);
        // lock0 released while port 1 waits
        step(1, RD,  5,   0,        RD,  200, 0,        2'b10, 16'hBEEF, 0);
        step(1, RD,  5,   0,        RD,  200, 0,        2'b01, 16'hA5A5, 0);
        // lock1, locked read of freshly written data, then owner drops req
        step(1, IDL, 0,   0,        WRL, 300, 16'h55AA, 2'b10, 0,        0);
        step(1, RD,  5,   0,        RDL, 300, 0,        2'b10, 16'h55AA, 0);
        step(1, RD,  5,   0,        IDL, 0,   0,        2'b01, 16'hA5A5, 0);
        step(1, IDL, 0,   0,        IDL, 0,   0,        2'b00, 0,        0);
        // read acked, reset asserted before its data would return
        step(1, RD,  5,   0,        IDL, 0,   0,        2'b01, 0,        1);
        step(0, RD,  5,   0,        IDL, 0,   0,        2'b00, 0,        0);
        step(1, RD,  10,  0,        RD,  11,  0,        2'b01, 16'h1111, 0);
        step(1, IDL, 0,   0,        IDL, 0,   0,        2'b00, 0,        0);
        step(1, IDL, 0,   0,        IDL, 0,   0,        2'b00, 0,        0);

        @(negedge clock);
        #1;
        n_tests = n_tests + 1;
        if (ack_q.size() != 0 || rd0_q.size() != 0 || rd1_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: pending ack=%0d rd0=%0d rd1=%0d, required 0 0 0",
                     ack_q.size(), rd0_q.size(), rd1_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
